// File: rtl/l2_request_queue_pkg.sv
// Shared request types for the L2 request path: the packet carried from the
// core-side arbiter to the L2 pipeline front end.
package l2_request_queue_pkg;

    typedef enum logic [1:0] {
        REQ_READ     = 2'd0,
        REQ_WRITE    = 2'd1,
        REQ_PREFETCH = 2'd2,
        REQ_EVICT    = 2'd3
    } l2req_type_e;

    typedef struct packed {
        logic        valid;
        logic [1:0]  core_id;
        l2req_type_e req_type;
        logic [31:0] addr;
    } l2req_packet_t;

endpackage

// File: rtl/l2_request_queue.sv
// In-order request queue between the L2 arbiter and the L2 pipeline front end.
// Ready depends only on registered state; the head is zeroed when empty.
module l2_request_queue
    import l2_request_queue_pkg::*;
#(
    parameter int DEPTH                 = 4,
    parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  l2req_packet_t            l2req_packet,
    output logic                     l2req_ready,
    output l2req_packet_t            l2q_packet,
    input  logic                     l2q_accept,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    l2req_packet_t mem [DEPTH];
    logic          enq;
    logic          deq;

    // A full queue refuses input even when the head is accepted this cycle,
    // keeping l2q_accept off the ready path.
    assign l2req_ready = (occupancy != CW'(DEPTH));
    assign enq         = l2req_packet.valid && l2req_ready;
    assign deq         = l2q_accept && (occupancy != '0);
    assign almost_full = (occupancy >= CW'(ALMOST_FULL_THRESHOLD));
    assign l2q_packet  = (occupancy != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            unique case ({enq, deq})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an empty queue masks the head
    // to zero, so stale entries are never observable and the array stays plain flops.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= l2req_packet;
    end

endmodule

// File: tb/tb_l2_request_queue.sv
// Directed bench for l2_request_queue: fill, drain with wrap, concurrent
// enqueue/dequeue, full-plus-accept, empty accept and mid-operation reset.
module tb_l2_request_queue;
    import l2_request_queue_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   reset;
    l2req_packet_t          l2req_packet;
    logic                   l2req_ready;
    l2req_packet_t          l2q_packet;
    logic                   l2q_accept;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   almost_full;

    int checks   = 0;
    int failures = 0;

    l2_request_queue #(.DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(DEPTH - 1)) dut (
        .clk          (clk),
        .reset        (reset),
        .l2req_packet (l2req_packet),
        .l2req_ready  (l2req_ready),
        .l2q_packet   (l2q_packet),
        .l2q_accept   (l2q_accept),
        .occupancy    (occupancy),
        .almost_full  (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic l2req_packet_t mk(input logic [7:0] id);
        l2req_packet_t p;
        p.valid    = 1'b1;
        p.core_id  = id[1:0];
        p.req_type = l2req_type_e'(id[3:2]);
        p.addr     = 32'hA000_0000 | {16'h0, id, 8'h40};
        return p;
    endfunction

    function automatic l2req_packet_t junk();
        l2req_packet_t p;
        p.valid    = 1'b0;
        p.core_id  = 2'b11;
        p.req_type = REQ_EVICT;
        p.addr     = 32'hDEAD_BEEF;
        return p;
    endfunction

    task automatic check_state(input string tag, input int occ, input logic rdy,
                               input logic af, input l2req_packet_t head);
        check({tag, "_occ"},  64'(occupancy),   64'(occ));
        check({tag, "_rdy"},  64'(l2req_ready), 64'(rdy));
        check({tag, "_af"},   64'(almost_full), 64'(af));
        check({tag, "_head"}, 64'(l2q_packet),  64'(head));
    endtask

    l2req_packet_t pa, pb, pc, pd, pe, pf, pg, ph, pi, pj, pk, pl, pm;

    initial begin
        pa = mk(8'h01); pb = mk(8'h02); pc = mk(8'h03); pd = mk(8'h04);
        pe = mk(8'h05); pf = mk(8'h06); pg = mk(8'h07); ph = mk(8'h08);
        pi = mk(8'h09); pj = mk(8'h0A); pk = mk(8'h0B); pl = mk(8'h0C);
        pm = mk(8'h0D);

        reset        = 1'b1;
        l2req_packet = '0;
        l2q_accept   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_state("reset", 0, 1'b1, 1'b0, '0);

        // Fill A..D with accept low; no bypass while the first write is pending.
        l2req_packet = pa;
        #1 check("no_bypass", 64'(l2q_packet), 64'(0));
        tick(); check_state("fill_a", 1, 1'b1, 1'b0, pa);
        l2req_packet = pb;
        tick(); check_state("fill_b", 2, 1'b1, 1'b0, pa);
        l2req_packet = pc;
        tick(); check_state("fill_c", 3, 1'b1, 1'b1, pa);
        l2req_packet = pd;
        tick(); check_state("fill_d", 4, 1'b0, 1'b1, pa);
        l2req_packet = pe;
        tick(); check_state("fill_e_rejected", 4, 1'b0, 1'b1, pa);

        // Full plus accept, then drain with wrap while E,F enter.
        l2q_accept = 1'b1;
        #1 check("full_accept_rdy", 64'(l2req_ready), 64'(0));
        tick(); check_state("drain1", 3, 1'b1, 1'b1, pb);
        tick(); check_state("drain2", 3, 1'b1, 1'b1, pc);
        l2req_packet = pf;
        tick(); check_state("drain3", 3, 1'b1, 1'b1, pd);
        l2req_packet = junk();
        tick(); check_state("drain4", 2, 1'b1, 1'b0, pe);
        tick(); check_state("drain5", 1, 1'b1, 1'b0, pf);
        tick(); check_state("drain6", 0, 1'b1, 1'b0, '0);

        // Simultaneous enqueue/dequeue at occupancy 2.
        l2q_accept   = 1'b0;
        l2req_packet = pg;
        tick();
        l2req_packet = ph;
        tick(); check_state("simul_pre", 2, 1'b1, 1'b0, pg);
        l2q_accept   = 1'b1;
        l2req_packet = pi;
        tick(); check_state("simul", 2, 1'b1, 1'b0, ph);
        l2req_packet = junk();
        tick(); check_state("simul_tail", 1, 1'b1, 1'b0, pi);
        tick(); check_state("simul_empty", 0, 1'b1, 1'b0, '0);

        // Accept while empty with an invalid but non-zero input.
        tick(); check_state("empty_accept1", 0, 1'b1, 1'b0, '0);
        tick(); check_state("empty_accept2", 0, 1'b1, 1'b0, '0);

        // Reset with three entries queued, then confirm pointers restarted.
        l2q_accept   = 1'b0;
        l2req_packet = pj;
        tick();
        l2req_packet = pk;
        tick();
        l2req_packet = pl;
        tick(); check_state("pre_reset", 3, 1'b1, 1'b1, pj);
        l2req_packet = '0;
        reset        = 1'b1;
        tick(); check_state("mid_reset", 0, 1'b1, 1'b0, '0);
        reset        = 1'b0;
        l2req_packet = pm;
        tick(); check_state("post_reset", 1, 1'b1, 1'b0, pm);
        l2req_packet = '0;
        l2q_accept   = 1'b1;
        tick(); check_state("post_reset_drain", 0, 1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
